// File: rtl/scan_scheduler.sv
// HUB-75 scan scheduler: walks every (row, bit plane) of a frame with BCM dwell weighting.
// Optional SCAN_SCHED_GHOST_BLANK_EN inserts BLANK_CYCLES dead cycles at each row change.
module scan_scheduler #(
   parameter int ROWS         = 32,
   parameter int ROW_BITS     = 5,
   parameter int PLANES       = 8,
   parameter int BASE_TICKS   = 16,
   parameter int BLANK_CYCLES = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic                driver_is_idle,
   output logic                driver_start,
   output logic [ROW_BITS-1:0] y,
   output logic [2:0]          plane,
   output logic [9:0]          frame_count,
   output logic                display_en,
   output logic                frame_done,
   output logic                busy
);

   localparam int CNT_W = $clog2(BASE_TICKS << (PLANES - 1)) + 1;
   localparam logic [ROW_BITS-1:0] Y_LAST     = ROW_BITS'(ROWS - 1);
   localparam logic [2:0]          PLANE_LAST = 3'(PLANES - 1);

   generate
      if (PLANES < 1 || PLANES > 8 || BLANK_CYCLES < 1 || ROWS < 1) begin : g_param_check
         $error("scan_scheduler: illegal parameter set");
      end
   endgenerate

`ifdef SCAN_SCHED_GHOST_BLANK_EN
   localparam int BLK_W = $clog2(BLANK_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DWELL, ADVANCE, BLANK} state_t;
   logic [BLK_W-1:0] blank_cnt;
   logic             frame_end_q;
`else
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DWELL, ADVANCE} state_t;
`endif

   state_t           state;
   logic [CNT_W-1:0] dwell_cnt;
   logic             plane_last;
   logic             frame_end;

   // Plane p is shown for BASE_TICKS << p cycles, giving binary brightness weights.
   function automatic logic [CNT_W-1:0] dwell_ticks(input logic [2:0] p);
      return CNT_W'(BASE_TICKS) << p;
   endfunction

   assign plane_last   = (plane == PLANE_LAST);
   assign frame_end    = plane_last && (y == Y_LAST);
   assign driver_start = (state == ISSUE);
   assign display_en   = (state == DWELL);
   assign busy         = (state != IDLE);
   assign frame_done   = (state == ADVANCE) && frame_end;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         y           <= '0;
         plane       <= '0;
         frame_count <= '0;
         dwell_cnt   <= '0;
`ifdef SCAN_SCHED_GHOST_BLANK_EN
         blank_cnt   <= '0;
         frame_end_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (enable) state <= ISSUE;
            end
            ISSUE: begin
               state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (!driver_is_idle) state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (driver_is_idle) begin
                  dwell_cnt <= dwell_ticks(plane);
                  state     <= DWELL;
               end
            end
            DWELL: begin
               dwell_cnt <= dwell_cnt - 1'b1;
               if (dwell_cnt == CNT_W'(1)) state <= ADVANCE;
            end
            ADVANCE: begin
               // Plane is the inner loop; the row only moves once all planes are shown.
               if (!plane_last) begin
                  plane <= plane + 3'd1;
               end else begin
                  plane <= '0;
                  y     <= (y == Y_LAST) ? '0 : y + 1'b1;
                  if (y == Y_LAST) frame_count <= frame_count + 10'd1;
               end
`ifdef SCAN_SCHED_GHOST_BLANK_EN
               if (plane_last) begin
                  blank_cnt   <= BLK_W'(BLANK_CYCLES);
                  frame_end_q <= frame_end;
                  state       <= BLANK;
               end else begin
                  state <= ISSUE;
               end
`else
               state <= (frame_end && !enable) ? IDLE : ISSUE;
`endif
            end
`ifdef SCAN_SCHED_GHOST_BLANK_EN
            BLANK: begin
               blank_cnt <= blank_cnt - 1'b1;
               if (blank_cnt == BLK_W'(1)) state <= (frame_end_q && !enable) ? IDLE : ISSUE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule
